load_store_unit: RTL and testbench

- Sits directly upstream of the 128x32 word-addressed data memory.
- Accepts a load/store request from the datapath and runs the memory access over several cycles.
- Adds byte and halfword support (lb/lbu/lh/lhu/sb/sh) to the word-only memory. Sub-word stores use an internal read-modify-write sequence.
- Detects misaligned and out-of-range accesses and reports them on the response.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and state type for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // 128 words x 4 bytes = 2^9 bytes of addressable data memory
    localparam int ADDR_LIMIT_BITS_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FAULT,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extraction, extension and store merge
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane select; loads extend the lane, stores replace only that lane
    always_comb begin
        byte_sel    = old_word[{offset, 3'b000} +: 8];
        half_sel    = old_word[{offset[1], 4'b0000} +: 16];
        load_value  = old_word;
        merged_word = old_word;
        case (size)
            SZ_BYTE: begin
                load_value = zero_ext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_value = zero_ext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_value  = old_word;
                merged_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store sequencer with sub-word RMW and fault check
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_LIMIT_BITS = ADDR_LIMIT_BITS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    lsu_state_t  state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic        req_fault;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Memory strobes come straight from the state so an async reset drops them at once
    assign req_ready = (state == ST_IDLE);
    assign MemRead   = (state == ST_RD);
    assign MemWrite  = (state == ST_WR);

    // Fault classification of the incoming request, highest priority first
    always_comb begin
        req_fault = 1'b0;
        if (req_size == SZ_ILL)
            req_fault = 1'b1;
        else if (req_size == SZ_HALF && req_addr[0])
            req_fault = 1'b1;
        else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        else if ((req_addr >> ADDR_LIMIT_BITS) != 32'h0)
            req_fault = 1'b1;
    end

    lsu_lane_align u_align (
        .offset      (r_off),
        .size        (r_size),
        .zero_ext    (r_uns),
        .old_word    (ReadData),
        .store_data  (r_wdata),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // Request capture, access sequencing and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_uns      <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            address    <= 32'h0;
            WriteData  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_off   <= req_addr[1:0];
                        r_wdata <= req_wdata;
                        address <= {req_addr[31:2], 2'b00};
                        if (req_fault) begin
                            state <= ST_FAULT;
                        end else if (!req_we) begin
                            state <= ST_RD;
                        end else if (req_size == SZ_WORD) begin
                            WriteData <= req_wdata;
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_we) begin
                        WriteData <= merged_word;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= load_value;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_FAULT: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] address, WriteData, ReadData;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    // Data memory: read captured on negedge, write committed on posedge
    logic [31:0] mem [0:127];
    logic [31:0] rd_q;
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
        end else if (MemWrite) begin
            mem[address[8:2]] <= WriteData;
        end
    end

    always @(negedge clk) begin
        if (MemRead) rd_q <= mem[address[8:2]];
    end

    assign ReadData = rd_q;

    int checks   = 0;
    int failures = 0;

    // Reference memory as a flat byte array
    logic [7:0] ref_b [0:511];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (a % nbytes(sz) != 0) return 1'b1;
        return a >= 32'd512;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int n = nbytes(sz);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_b[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b = int'(a) & ~3;
        return {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
    endfunction

    // One request from idle to response, checked against the reference model
    task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
        logic        flt, got;
        logic [31:0] exp_rd, exp_wd, seen_wd, seen_addr;
        int          exp_lat, lat, n_rd, n_wr;
        flt    = ref_fault(sz, a);
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        if (flt) begin
            exp_lat = 2;
        end else if (!we) begin
            exp_lat = 2;
            exp_rd  = ref_load(sz, uns, a);
        end else begin
            ref_store(sz, a, wd);
            exp_wd  = ref_word(a);
            exp_lat = (nbytes(sz) == 4) ? 2 : 3;
        end
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; n_rd = 0; n_wr = 0; got = 1'b0; seen_wd = 32'h0; seen_addr = 32'h0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            n_rd += int'(MemRead);
            n_wr += int'(MemWrite);
            if (MemWrite) seen_wd = WriteData;
            if (MemRead || MemWrite) seen_addr = address;
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(resp_err), 32'(flt));
        check({tag, " rdata"}, resp_rdata, exp_rd);
        if (flt) begin
            check({tag, " no mem access"}, 32'(n_rd + n_wr), 32'h0);
        end else begin
            check({tag, " mem address"}, seen_addr, {a[31:2], 2'b00});
            if (we) begin
                check({tag, " write cycles"}, 32'(n_wr), 32'h1);
                check({tag, " WriteData"}, seen_wd, exp_wd);
                check({tag, " mem word"}, mem[a[8:2]], exp_wd);
            end else begin
                check({tag, " read cycles"}, 32'(n_rd), 32'h1);
            end
        end
    endtask

    logic        b_we  [4];
    logic [1:0]  b_sz  [4];
    logic [31:0] b_a   [4];
    logic [31:0] b_wd  [4];
    logic        b_err [4];
    logic [31:0] b_rd  [4];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc, got;
        int          idx, nresp;
        logic [1:0]  sz;
        logic [31:0] a;

        for (int i = 0; i < 512; i++) ref_b[i] = 8'h0;
        reset = 1'b0; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'h1);
        check("rst resp_valid", 32'(resp_valid), 32'h0);
        check("rst resp_err", 32'(resp_err), 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst MemRead", 32'(MemRead), 32'h0);
        check("rst MemWrite", 32'(MemWrite), 32'h0);
        check("rst address", address, 32'h0);
        check("rst WriteData", WriteData, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;

        run_req("sw10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run_req("lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        run_req("sw20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344);
        run_req("sb22", 1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h0000_00AB);
        check("sb22 merged", mem[8], 32'h11AB_3344);
        run_req("sw30", 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h80FF_7F01);
        run_req("lb32", 1'b0, SZ_BYTE, 1'b0, 32'h32, 32'h0);
        check("lb32 value", resp_rdata, 32'hFFFF_FFFF);
        run_req("lbu33", 1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0);
        check("lbu33 value", resp_rdata, 32'h0000_0080);
        run_req("lh30", 1'b0, SZ_HALF, 1'b0, 32'h30, 32'h0);
        check("lh30 value", resp_rdata, 32'h0000_7F01);
        run_req("lh32", 1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0);
        check("lh32 value", resp_rdata, 32'hFFFF_80FF);
        run_req("sh32", 1'b1, SZ_HALF, 1'b0, 32'h32, 32'h1234_5678);

        run_req("flt lw06", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0);
        run_req("flt sh05", 1'b1, SZ_HALF, 1'b0, 32'h05, 32'hFFFF);
        run_req("flt size3", 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0);
        run_req("flt lw200", 1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0);
        run_req("flt sw8000", 1'b1, SZ_WORD, 1'b0, 32'h8000_0010, 32'h1);

        // Reset while the sub-word store is in its write cycle
        run_req("sw40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h41; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (MemWrite) got = 1'b1;
        end
        check("rst_mid write reached", 32'(got), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid MemWrite drop", 32'(MemWrite), 32'h0);
        check("rst_mid MemRead", 32'(MemRead), 32'h0);
        check("rst_mid req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid no resp", 32'(resp_valid), 32'h0);
        end
        check("rst_mid mem kept", mem[16], 32'hCAFE_F00D);
        run_req("lw40 after rst", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);

        // Randomized traffic over a small window so loads revisit stored data
        for (int k = 0; k < 40; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(9, 31));
            run_req("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        // Back-to-back with req_valid held high
        b_we[0] = 1'b1; b_sz[0] = SZ_WORD; b_a[0] = 32'h80; b_wd[0] = 32'h89AB_CDEF;
        b_we[1] = 1'b0; b_sz[1] = SZ_HALF; b_a[1] = 32'h82; b_wd[1] = 32'h0;
        b_we[2] = 1'b1; b_sz[2] = SZ_BYTE; b_a[2] = 32'h81; b_wd[2] = 32'h12;
        b_we[3] = 1'b0; b_sz[3] = SZ_WORD; b_a[3] = 32'h80; b_wd[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b_err[i] = ref_fault(b_sz[i], b_a[i]);
            b_rd[i]  = 32'h0;
            if (!b_err[i]) begin
                if (b_we[i]) ref_store(b_sz[i], b_a[i], b_wd[i]);
                else         b_rd[i] = ref_load(b_sz[i], 1'b0, b_a[i]);
            end
        end
        idx = 0; nresp = 0;
        req_valid = 1'b1; req_we = b_we[0]; req_size = b_sz[0]; req_unsigned = 1'b0;
        req_addr = b_a[0]; req_wdata = b_wd[0];
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            @(negedge clk);
            if (resp_valid || MemRead || MemWrite) check("b2b ready low", 32'(req_ready), 32'h0);
            if (resp_valid) begin
                if (nresp < 4) begin
                    check("b2b err", 32'(resp_err), 32'(b_err[nresp]));
                    check("b2b rdata", resp_rdata, b_rd[nresp]);
                end
                nresp++;
            end
            acc = req_ready && req_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    req_we = b_we[idx]; req_size = b_sz[idx];
                    req_addr = b_a[idx]; req_wdata = b_wd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b resp count", 32'(nresp), 32'h4);
        check("b2b final mem", mem[32], 32'h89AB_12EF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("b2b no extra resp", 32'(resp_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
